// File: rtl/serial_seq_detector_pkg.sv
// Shared types and constants for the serial start-sequence detector.
// Holds the FSM state enum, default pattern/load value and the seven-segment table.
package serial_seq_detector_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    SHIFT = 3'd4
  } state_e;

  localparam logic [3:0] SEQ_PATTERN  = 4'b1101;
  localparam logic [3:0] SEQ_LOAD_VAL = 4'd8;

  // Active-low segments, bit6..0 = g..a; entry 15 listed first.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    return SEG_LUT[val];
  endfunction

endpackage

// File: rtl/pb_one_pulser.sv
// Push-button conditioning: 2-flop synchronizer plus a one-cycle pulse on each
// synchronized rising edge. A level already high at reset release never fires.
module pb_one_pulser (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic warm_q,  warm_d;
  logic armed_q, armed_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = pb;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    warm_d  = 1'b1;
    // Only arm once a genuine low has been sampled, so a button held through reset is ignored.
    armed_d = armed_q | (warm_q & ~sync1_q);
    pulse_d = sync2_q & ~prev_q & armed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/serial_seq_detector_top.sv
// Detects PATTERN on a button-stepped serial stream, then passes the next
// 16-LOAD_VAL bits through as payload while showing the count on a 7-seg display.
module serial_seq_detector_top
  import serial_seq_detector_pkg::*;
#(
  parameter logic [3:0] PATTERN  = SEQ_PATTERN,
  parameter logic [3:0] LOAD_VAL = SEQ_LOAD_VAL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkPB,
  input  logic       serIn,
  output logic [6:0] r_Hex_Encoding,
  output logic       serOut,
  output logic       serOutValid
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       clk_en;
  logic       load;
  logic       cnt_reset;
  logic       co;

  pb_one_pulser u_pb (
    .clk   (clk),
    .rst_n (rst),
    .pb    (clkPB),
    .pulse (clk_en)
  );

  assign co = (cnt_q == 4'hF);

  // Fallback arcs on mismatch are the overlap-correct ones for the default pattern.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE:  if (serIn == PATTERN[3]) state_d = S1;
        S1:    state_d = (serIn == PATTERN[2]) ? S11 : IDLE;
        S11:   if (serIn == PATTERN[1]) state_d = S110;
        S110: begin
          if (serIn == PATTERN[0]) begin
            state_d = SHIFT;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: if (co) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_reset = (state_q != SHIFT);
    cnt_d     = cnt_q;
    if (load)           cnt_d = LOAD_VAL;
    else if (cnt_reset) cnt_d = 4'd0;
    else if (clk_en)    cnt_d = co ? 4'd0 : cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign serOutValid    = (state_q == SHIFT);
  assign serOut         = serOutValid & serIn;
  assign r_Hex_Encoding = seg_decode(cnt_q);

endmodule

// File: tb/tb_serial_seq_detector_top.sv
// Bench for serial_seq_detector_top: directed and random button presses checked
// against a suffix-matching reference model with a payload bit budget.
module tb_serial_seq_detector_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clkPB = 1'b0;
  logic       serIn = 1'b0;
  logic [6:0] hex;
  logic       serOut;
  logic       serOutValid;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [3:0] PAT = 4'b1101;

  // Reference model: last bits seen since IDLE, and payload bits still owed.
  int         rem  = 0;
  int         nb   = 0;
  logic [3:0] hist = 4'd0;

  always #5 clk = ~clk;

  serial_seq_detector_top dut (
    .clk            (clk),
    .rst            (rst),
    .clkPB          (clkPB),
    .serIn          (serIn),
    .r_Hex_Encoding (hex),
    .serOut         (serOut),
    .serOutValid    (serOutValid)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_exp(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic void model_reset();
    rem  = 0;
    nb   = 0;
    hist = 4'd0;
  endfunction

  function automatic void model_bit(input logic b);
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        nb   = 0;
        hist = 4'd0;
      end
    end else begin
      hist = {hist[2:0], b};
      nb++;
      if (nb >= 4 && hist == PAT) rem = 8;
    end
  endfunction

  function automatic int exp_cnt();
    return (rem > 0) ? 16 - rem : 0;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".vld"}, serOutValid, (rem > 0) ? 1 : 0);
    chk({tag, ".sout"}, serOut, (rem > 0) ? serIn : 1'b0);
    chk({tag, ".hex"}, hex, seg_exp(exp_cnt()));
  endtask

  // One button press: hold for 'hold' edges, expect exactly one clk_en at edge 3.
  task automatic press(input logic b, input int hold);
    int pulses;
    int at;
    pulses = 0;
    at = -1;
    @(negedge clk);
    serIn = b;
    clkPB = 1'b1;
    #1 check_outs("pre");
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (dut.clk_en) begin
        pulses++;
        at = i;
      end
    end
    @(negedge clk);
    clkPB = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (dut.clk_en) pulses++;
    end
    chk("pulses", pulses, 1);
    chk("latency", at, 3);
    model_bit(b);
    check_outs("post");
  endtask

  task automatic press_seq(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) press(v[i], $urandom_range(4, 8));
  endtask

  task automatic payload_rand();
    for (int i = 0; i < 8; i++) press(1'($urandom_range(0, 1)), $urandom_range(4, 8));
  endtask

  initial begin
    int pulses;
    // Reset state, with the button already held high.
    clkPB = 1'b1;
    #12;
    model_reset();
    check_outs("rst");
    chk("rst.clken", dut.clk_en, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (dut.clk_en) pulses++;
    end
    chk("held_at_release", pulses, 0);
    @(negedge clk);
    clkPB = 1'b0;
    repeat (4) @(posedge clk);

    // Long hold, then the basic detection and a full payload.
    press(1'b1, 10);
    press_seq(16'b101, 3);
    chk("detect.hex8", hex, 7'b0000000);
    chk("detect.vld", serOutValid, 1);
    press_seq(16'b01111111, 8);
    chk("done.hex0", hex, 7'b1000000);
    chk("done.vld", serOutValid, 0);

    // Overlapping prefixes and a near miss.
    press_seq(16'b11101, 5);
    chk("ovl1.vld", serOutValid, 1);
    payload_rand();
    press_seq(16'b101101, 6);
    chk("ovl2.vld", serOutValid, 1);
    payload_rand();
    press_seq(16'b1100, 4);
    chk("nodet.vld", serOutValid, 0);

    // Pattern inside the payload must not retrigger.
    press_seq(16'b1101, 4);
    press_seq(16'b11011101, 8);
    chk("nore.vld", serOutValid, 0);

    // Asynchronous reset in the middle of a payload at count B.
    press_seq(16'b1101, 4);
    press_seq(16'b000, 3);
    chk("midB.hex", hex, seg_exp(11));
    @(negedge clk);
    serIn = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outs("arst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    press(1'b1, 5);
    chk("after_rst.vld", serOutValid, 0);
    press_seq(16'b101, 3);
    chk("after_rst.det", serOutValid, 1);
    payload_rand();

    // Random stream.
    for (int i = 0; i < 200; i++) press(1'($urandom_range(0, 1)), $urandom_range(4, 9));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_seq_detector_top.md
SERIAL_SEQ_DETECTOR_TOP -- requirements
Module: serial_seq_detector_top

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameters, one per line (name, default, meaning): PATTERN, 4'b1101, start sequence, MSB received first; LOAD_VAL, 4'd8, counter load value, giving a payload of 16-LOAD_VAL = 8 bits.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- clkPB, in, 1, raw asynchronous push-button that advances the serial stream.
- serIn, in, 1, serial data, sampled on each button press.
- r_Hex_Encoding, out, 7, seven-segment pattern of the 4-bit count, active-low, bit6..0 = g..a.
- serOut, out, 1, payload bit.
- serOutValid, out, 1, high while serOut carries payload.

Function
REQ-004 SHALL pass clkPB through a 2-flop synchronizer, then assert internal clkEn for exactly one clk cycle per synchronized rising edge.
- Holding clkPB high SHALL produce no further pulses.
- Button-to-clkEn latency SHALL be 3 clk edges.
REQ-005 All FSM and counter state SHALL advance only in cycles where clkEn=1; otherwise state SHALL hold.
REQ-006 FSM states SHALL be IDLE, S1, S11, S110 and SHIFT.
REQ-007 Transitions on clkEn, by current state and serIn:
- IDLE: 1 -> S1; 0 -> IDLE.
- S1: 1 -> S11; 0 -> IDLE.
- S11: 1 -> S11; 0 -> S110.
- S110: 1 -> SHIFT; 0 -> IDLE.
REQ-008 On the S110->SHIFT transition the FSM SHALL pulse load, setting the counter to LOAD_VAL on that same edge.
REQ-009 In SHIFT, each clkEn SHALL increment the 4-bit counter.
REQ-010 Co SHALL be combinational (count==4'hF). clkEn with Co=1 in SHIFT SHALL return the FSM to IDLE and clear the counter to 0.
REQ-011 In IDLE, S1, S11 and S110 the counter SHALL be held at 0 (cnt_reset asserted).
REQ-012 serOutValid SHALL be 1 exactly while the state is SHIFT (Moore output).
- serOut SHALL equal serIn combinationally while in SHIFT, and 0 otherwise.
- Exactly 8 bits (counts 8..F) SHALL be delivered per detection.
REQ-013 Bits received during SHIFT SHALL NOT be examined for PATTERN. Detection SHALL restart from IDLE after the last payload bit.
REQ-014 r_Hex_Encoding SHALL be a combinational decode of the count, active-low, g..a. Values include:
- 0 = 1000000
- 8 = 0000000
- 9 = 0010000
- A = 0001000
- b = 0000011
- C = 1000110
- d = 0100001
- E = 0000110
- F = 0001110

Reset
REQ-015 While rst=0, regardless of clk, the design SHALL hold:
- state = IDLE;
- counter = 0;
- synchronizer and edge flops = 0;
- serOutValid = 0, serOut = 0, r_Hex_Encoding = 1000000.
REQ-016 Reset asserted mid-SHIFT SHALL abort the payload immediately. After release, a full PATTERN SHALL be required before the next payload.
REQ-017 A clkPB level already high at reset release SHALL NOT generate a clkEn.

Structure
REQ-018 A shared package SHALL hold the FSM state enum, PATTERN, LOAD_VAL and the 16-entry seven-segment lookup constant.
REQ-019 The button conditioning (synchronizer plus rising-edge one-pulse) SHALL be a separate sub-module named pb_one_pulser. The counter, FSM and decoder SHALL be inline.

Verification
REQ-020 Button held high for 10 clk cycles -> exactly one clkEn, 3 clk edges after the rising edge; no clkEn while held or on release.
REQ-021 Presses with serIn = 1,1,0,1 -> after the 4th press: state SHIFT, serOutValid=1, count=8, r_Hex_Encoding=0000000.
REQ-022 Continue with 8 presses, serIn = 0,1,1,1,1,1,1,1 -> serOut tracks serIn; display steps 8,9,A,b,C,d,E,F; after the 8th press serOutValid=0, count=0, display=1000000.
REQ-023 Overlap: serIn = 1,1,1,0,1 -> detection on the 5th press. serIn = 1,0,1,1,0,1 -> detection on the 6th press. serIn = 1,1,0,0 -> no detection.
REQ-024 Payload contains 1,1,0,1 -> no re-detection during SHIFT; IDLE is reached only after the 8th bit.
REQ-025 rst driven 0 between clk edges at count=B -> outputs reach reset values immediately. After release, one press with serIn=1 -> state S1, serOutValid=0.
